// File: rtl/csa_accumulate_resolve.sv
// Carry-save frame accumulator: folds (a,b,c) beats into a redundant sum/carry pair,
// then resolves it digit-serially to binary and presents the total on valid/ready.
module csa_accumulate_resolve #(
    parameter int W        = 4,
    parameter int ACC_W    = 8,
    parameter int RES_BITS = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     a,
    input  logic [W-1:0]     b,
    input  logic [W-1:0]     c,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_sum
);

    localparam int NDIG  = ACC_W / RES_BITS;
    localparam int CNT_W = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NDIG - 1);

    if (ACC_W % RES_BITS != 0) begin : g_chk_res
        $error("ACC_W must be a multiple of RES_BITS");
    end
    if (ACC_W < W + 2) begin : g_chk_w
        $error("ACC_W must be at least W+2");
    end

    typedef enum logic [1:0] {
        ST_ACC,
        ST_RESOLVE,
        ST_OUT
    } state_t;

    state_t              state_q;
    logic [ACC_W-1:0]    s_q, c_q;
    logic [CNT_W-1:0]    cnt_q;
    logic                in_ready_q, out_valid_q;
    logic [ACC_W-1:0]    out_sum_q;
    logic [ACC_W-1:0]    res_q;
    logic                cy_q;

    logic [ACC_W-1:0]    s_d, c_d;
    logic [ACC_W-1:0]    base_s, base_c;
    logic [ACC_W-1:0]    l1_s, l1_c, l2_s, l2_c;
    logic [RES_BITS:0]   dig;
    logic [ACC_W-1:0]    res_d;

    // 3:2 compressor; the carry vector is already weighted (shifted) and truncated.
    function automatic logic [2*ACC_W-1:0] csa32(input logic [ACC_W-1:0] x,
                                                  input logic [ACC_W-1:0] y,
                                                  input logic [ACC_W-1:0] z);
        logic [ACC_W-1:0] sum, maj;
        sum = x ^ y ^ z;
        maj = (x & y) | (x & z) | (y & z);
        return {maj << 1, sum};
    endfunction

    always_comb begin
        base_s = clr ? '0 : s_q;
        base_c = clr ? '0 : c_q;
        {l1_c, l1_s} = csa32(ACC_W'(a), ACC_W'(b), ACC_W'(c));
        {l2_c, l2_s} = csa32(base_s, base_c, l1_s);
        {c_d, s_d}   = csa32(l2_s, l2_c, l1_c);
    end

    // One resolved digit per cycle, shifted in from the top of the result register.
    always_comb begin
        dig   = {1'b0, s_q[RES_BITS-1:0]} + {1'b0, c_q[RES_BITS-1:0]}
              + {{RES_BITS{1'b0}}, cy_q};
        res_d = ACC_W'({dig[RES_BITS-1:0], res_q} >> RES_BITS);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_ACC;
            s_q         <= '0;
            c_q         <= '0;
            cnt_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            out_sum_q   <= '0;
        end else begin
            case (state_q)
                ST_ACC: begin
                    if (in_valid) begin
                        s_q <= s_d;
                        c_q <= c_d;
                        if (in_last) begin
                            state_q    <= ST_RESOLVE;
                            cnt_q      <= '0;
                            in_ready_q <= 1'b0;
                        end
                    end else if (clr) begin
                        s_q <= '0;
                        c_q <= '0;
                    end
                end
                ST_RESOLVE: begin
                    s_q   <= s_q >> RES_BITS;
                    c_q   <= c_q >> RES_BITS;
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == CNT_LAST) begin
                        out_sum_q   <= res_d;
                        out_valid_q <= 1'b1;
                        state_q     <= ST_OUT;
                    end
                end
                ST_OUT: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        out_sum_q   <= '0;
                        s_q         <= '0;
                        c_q         <= '0;
                        in_ready_q  <= 1'b1;
                        state_q     <= ST_ACC;
                    end
                end
                default: begin
                    state_q    <= ST_ACC;
                    in_ready_q <= 1'b1;
                end
            endcase
        end
    end

    // Resolve datapath: carry is zeroed while accumulating so each frame starts clean.
    always_ff @(posedge clk) begin
        if (state_q == ST_RESOLVE) begin
            cy_q  <= dig[RES_BITS];
            res_q <= res_d;
        end else begin
            cy_q  <= 1'b0;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_sum   = out_sum_q;

endmodule

// File: tb/tb_csa_accumulate_resolve.sv
// Bench for csa_accumulate_resolve: directed scenarios plus randomized frames
// checked against an integer running-sum model.
module tb_csa_accumulate_resolve;

    localparam int W        = 4;
    localparam int ACC_W    = 8;
    localparam int RES_BITS = 2;
    localparam int NDIG     = ACC_W / RES_BITS;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             clr = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [W-1:0]     a = '0, b = '0, c = '0;
    logic             in_last = 1'b0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [ACC_W-1:0] out_sum;

    int n_tests = 0;
    int n_fail  = 0;
    int ref_sum = 0;

    csa_accumulate_resolve #(.W(W), .ACC_W(ACC_W), .RES_BITS(RES_BITS)) dut (
        .clk(clk), .rst_n(rst_n), .clr(clr),
        .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .c(c), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic send_beat(input int va, input int vb, input int vc,
                             input bit last, input bit vclr);
        int n = 0;
        while (!in_ready && n < 50) begin
            @(posedge clk); #1; n++;
        end
        check("in_ready_wait", in_ready, 1);
        a = W'(va); b = W'(vb); c = W'(vc);
        in_last = last; clr = vclr; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0; clr = 1'b0; in_last = 1'b0;
        if (vclr) ref_sum = 0;
        ref_sum = (ref_sum + va + vb + vc) % (1 << ACC_W);
    endtask

    task automatic idle(input bit vclr);
        clr = vclr;
        @(posedge clk); #1;
        clr = 1'b0;
        if (vclr) ref_sum = 0;
    endtask

    // Called right after the edge that accepted in_last.
    task automatic finish_frame(input int bp, input bit junk, input int exp);
        int n = 0;
        if (junk) begin
            a = '1; b = '1; c = '1; in_last = 1'b1; clr = 1'b1; in_valid = 1'b1;
        end
        while (!out_valid && n < 20) begin
            check("resolve_in_ready", in_ready, 0);
            @(posedge clk); #1; n++;
        end
        in_valid = 1'b0; clr = 1'b0; in_last = 1'b0;
        check("latency", n, NDIG);
        check("out_valid", out_valid, 1);
        check("out_sum", out_sum, exp);
        out_ready = 1'b0;
        repeat (bp) begin
            @(posedge clk); #1;
            check("bp_valid", out_valid, 1);
            check("bp_sum", out_sum, exp);
            check("bp_in_ready", in_ready, 0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("hs_valid", out_valid, 0);
        check("hs_sum", out_sum, 0);
        check("hs_in_ready", in_ready, 1);
        ref_sum = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bit rose;
        // Reset state, held in reset then released
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_sum", out_sum, 0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        check("rel_in_ready", in_ready, 1);
        check("rel_out_valid", out_valid, 0);

        // Single beat
        send_beat(5, 6, 7, 1, 0);
        finish_frame(0, 0, 18);

        // Asynchronous reset while presenting a result
        send_beat(1, 2, 3, 1, 0);
        repeat (NDIG) @(posedge clk);
        #1;
        check("pre_rst_valid", out_valid, 1);
        check("pre_rst_sum", out_sum, 6);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_valid", out_valid, 0);
        check("async_rst_sum", out_sum, 0);
        check("async_rst_in_ready", in_ready, 1);
        @(negedge clk); rst_n = 1'b1; ref_sum = 0;
        @(posedge clk); #1;

        // Wrap and multi-beat frames
        for (int i = 0; i < 6; i++) send_beat(15, 15, 15, i == 5, 0);
        finish_frame(0, 0, 14);
        for (int i = 0; i < 3; i++) send_beat(15, 15, 15, i == 2, 0);
        finish_frame(0, 0, 135);

        // Backpressure, then a fresh frame
        send_beat(7, 3, 9, 1, 0);
        finish_frame(3, 0, 19);
        send_beat(1, 1, 1, 1, 0);
        finish_frame(0, 0, 3);

        // Clear with beat, clear alone
        send_beat(10, 0, 0, 0, 0);
        send_beat(1, 2, 3, 1, 1);
        finish_frame(0, 0, 6);
        send_beat(9, 9, 9, 0, 0);
        idle(1);
        send_beat(4, 0, 0, 1, 0);
        finish_frame(0, 0, 4);

        // Reset during second resolve cycle
        send_beat(9, 9, 9, 1, 0);
        @(posedge clk); #1;
        #1 rst_n = 1'b0;
        #1;
        check("mid_rst_in_ready", in_ready, 1);
        @(negedge clk); rst_n = 1'b1; ref_sum = 0;
        rose = 1'b0;
        repeat (8) begin
            @(posedge clk); #1;
            if (out_valid) rose = 1'b1;
        end
        check("mid_rst_no_valid", rose, 0);
        send_beat(2, 2, 2, 1, 0);
        finish_frame(0, 0, 6);

        // Randomized frames against the running-sum model
        for (int f = 0; f < 40; f++) begin
            int nb;
            nb = $urandom_range(1, 8);
            for (int k = 0; k < nb; k++) begin
                if ($urandom_range(0, 3) == 0) idle($urandom_range(0, 4) == 0);
                send_beat($urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 15),
                          k == nb - 1, $urandom_range(0, 9) == 0);
            end
            finish_frame($urandom_range(0, 3), $urandom_range(0, 1), ref_sum);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
